vga_sync_receiver: RTL and testbench

Recovers pixel coordinates and lock status from a VGA `h_sync`/`v_sync` pair. It is the receiving end of the `hvsync_generator` timing interface. The block sits beside the generator on the same `clk` and serves two purposes: a self-checking timing monitor in the pong/snake top, and a front end for an overlay that has only the sync wires. It measures line length and lines per frame, locks after two matching frames, and regenerates `pixel_x`/`pixel_y`/`in_active`.

---
 rtl/vga_sync_receiver_if.sv | 26 ++
 rtl/vga_sync_receiver.sv | 157 +++++++++++++++
 tb/tb_vga_sync_receiver.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_receiver_if.sv
// Sync-pair interface between an hvsync-style timing source and the receiver.
// The master drives the syncs; the slave returns recovered timing and coordinates.
interface vga_sync_receiver_if;
  logic        h_sync;
  logic        v_sync;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        in_active;
  logic        locked;
  logic        frame_start;
  logic        sync_err;
  logic [10:0] line_len;
  logic [10:0] frame_lines;

  modport master (
    output h_sync, v_sync,
    input  pixel_x, pixel_y, in_active, locked, frame_start, sync_err,
           line_len, frame_lines
  );

  modport slave (
    input  h_sync, v_sync,
    output pixel_x, pixel_y, in_active, locked, frame_start, sync_err,
           line_len, frame_lines
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// Recovers line/frame timing from an h_sync/v_sync pair, locks after two
// matching frames and regenerates active-area pixel coordinates.
module vga_sync_receiver #(
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int H_START         = 144,
  parameter int H_ACTIVE        = 640,
  parameter int V_START         = 35,
  parameter int V_ACTIVE        = 480
) (
  input  logic               clk,
  input  logic               reset,
  vga_sync_receiver_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic        POL     = (SYNC_ACTIVE_LOW != 0);
  localparam logic [10:0] CNT_MAX = '1;
  localparam logic [10:0] H_LO    = 11'(H_START);
  localparam logic [10:0] H_HI    = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_START);
  localparam logic [10:0] V_HI    = 11'(V_START + V_ACTIVE);

  state_t      state;
  logic        h_s1, h_s2, v_s1, v_s2;
  logic        h_edge, v_edge;
  logic [10:0] h_cnt, v_cnt, h_meas;
  logic [10:0] line_len_r, frame_lines_r;
  logic [1:0]  h_stage;
  logic        have_frame, bad, bad_now;
  logic        err_q, fs_q, win;

  assign h_edge = h_s1 & ~h_s2;
  assign v_edge = v_s1 & ~v_s2;
  assign h_meas = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 11'd1;

  always_comb begin
    bad_now = bad;
    if (h_edge && (h_stage == 2'd2) && (h_meas != line_len_r))
      bad_now = 1'b1;
  end

  always_comb begin
    win = (state == LOCKED) && (h_cnt >= H_LO) && (h_cnt < H_HI)
          && (v_cnt >= V_LO) && (v_cnt < V_HI);
  end

  // Polarity-normalised syncs, two stages for edge detection, plus counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_s1  <= 1'b0;
      h_s2  <= 1'b0;
      v_s1  <= 1'b0;
      v_s2  <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_s1 <= bus.h_sync ^ POL;
      h_s2 <= h_s1;
      v_s1 <= bus.v_sync ^ POL;
      v_s2 <= v_s1;
      if (h_edge)
        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + 11'd1;
      // v-edge wins over a coincident h-edge so the new frame starts at row 0
      if (v_edge)
        v_cnt <= '0;
      else if (h_edge && (v_cnt != CNT_MAX))
        v_cnt <= v_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= SEARCH;
      h_stage       <= 2'd0;
      have_frame    <= 1'b0;
      bad           <= 1'b0;
      line_len_r    <= '0;
      frame_lines_r <= '0;
      err_q         <= 1'b0;
      fs_q          <= 1'b0;
    end else begin
      err_q <= 1'b0;
      fs_q  <= v_edge;
      case (state)
        SEARCH: begin
          if (v_edge) begin
            state      <= MEASURE;
            h_stage    <= 2'd0;
            have_frame <= 1'b0;
            bad        <= 1'b0;
          end
        end
        MEASURE: begin
          // Stage 0 drops the partial line seen on entry; stage 1 captures.
          if (h_edge) begin
            case (h_stage)
              2'd0:    h_stage <= 2'd1;
              2'd1: begin
                line_len_r <= h_meas;
                h_stage    <= 2'd2;
              end
              default: bad <= bad_now;
            endcase
          end
          if (v_edge) begin
            if (!have_frame) begin
              frame_lines_r <= v_cnt;
              have_frame    <= 1'b1;
              bad           <= 1'b0;
            end else if (!bad_now && (v_cnt == frame_lines_r)) begin
              state <= LOCKED;
            end else begin
              frame_lines_r <= v_cnt;
              bad           <= 1'b0;
              h_stage       <= 2'd1;
            end
          end
        end
        LOCKED: begin
          if ((h_edge && (h_meas != line_len_r)) ||
              (v_edge && (v_cnt != frame_lines_r)) ||
              (h_cnt == CNT_MAX) || (v_cnt == CNT_MAX)) begin
            state <= SEARCH;
            err_q <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.pixel_x     <= '0;
      bus.pixel_y     <= '0;
      bus.in_active   <= 1'b0;
      bus.locked      <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.sync_err    <= 1'b0;
      bus.line_len    <= '0;
      bus.frame_lines <= '0;
    end else begin
      bus.in_active   <= win;
      bus.pixel_x     <= win ? 10'(h_cnt - H_LO) : '0;
      bus.pixel_y     <= win ? 10'(v_cnt - V_LO) : '0;
      bus.locked      <= (state == LOCKED);
      bus.frame_start <= fs_q;
      bus.sync_err    <= err_q;
      bus.line_len    <= line_len_r;
      bus.frame_lines <= frame_lines_r;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 80x30 raster; one DUT
// sees low-true syncs, a second sees the inverted high-true copy.
module tb_vga_sync_receiver;

  localparam int HS_W  = 8;
  localparam int LINE  = 80;
  localparam int LINES = 30;
  localparam int HST   = 16;
  localparam int HACT  = 48;
  localparam int VST   = 4;
  localparam int VACT  = 20;
  localparam int VOFF  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_sync_receiver_if a_if ();
  vga_sync_receiver_if b_if ();

  vga_sync_receiver #(
    .SYNC_ACTIVE_LOW(1), .H_START(HST), .H_ACTIVE(HACT),
    .V_START(VST), .V_ACTIVE(VACT)
  ) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));

  vga_sync_receiver #(
    .SYNC_ACTIVE_LOW(0), .H_START(HST), .H_ACTIVE(HACT),
    .V_START(VST), .V_ACTIVE(VACT)
  ) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  logic [45:0] outs_a, outs_b;
  assign outs_a = {a_if.pixel_x, a_if.pixel_y, a_if.in_active, a_if.locked,
                   a_if.frame_start, a_if.sync_err, a_if.line_len, a_if.frame_lines};
  assign outs_b = {b_if.pixel_x, b_if.pixel_y, b_if.in_active, b_if.locked,
                   b_if.frame_start, b_if.sync_err, b_if.line_len, b_if.frame_lines};

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int vsamp, hsamp, last_h, lock_rise, err_cyc, rise_cyc;
  int fs_cnt, err_cnt, act_cnt, rst_nz, ab_diff, idle_nz;
  int rise_px, rise_py, last_px, last_py;
  logic prev_lock = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    fs_cnt = 0; err_cnt = 0; act_cnt = 0;
    err_cyc = -1; rise_cyc = -1; lock_rise = -1;
    rise_px = -1; rise_py = -1; last_px = -1; last_py = -1;
  endtask

  task automatic set_pins(input bit h, input bit v);
    a_if.h_sync = ~h; a_if.v_sync = ~v;
    b_if.h_sync = h;  b_if.v_sync = v;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (!reset && outs_a != '0) rst_nz++;
    if (outs_a !== outs_b) ab_diff++;
    if (a_if.frame_start) fs_cnt++;
    if (a_if.sync_err) begin err_cnt++; err_cyc = cyc; end
    if (a_if.locked && !prev_lock) lock_rise = cyc;
    prev_lock = a_if.locked;
    if (a_if.in_active) begin
      if (act_cnt == 0) begin
        rise_cyc = cyc; rise_px = int'(a_if.pixel_x); rise_py = int'(a_if.pixel_y);
      end
      act_cnt++;
      last_px = int'(a_if.pixel_x); last_py = int'(a_if.pixel_y);
    end else if (a_if.pixel_x != '0 || a_if.pixel_y != '0) begin
      idle_nz++;
    end
  endtask

  // Inputs set here are sampled at the following edge, numbered cyc+1.
  task automatic drive_line(input int l, input int len, input int voff);
    for (int c = 0; c < len; c++) begin
      bit h, v;
      h = (c < HS_W);
      v = (l == 0 && c >= voff) || (l == 1) || (l == 2 && c < voff);
      set_pins(h, v);
      if (c == 0) last_h = cyc + 1;
      if (l == 0 && c == voff) vsamp = cyc + 1;
      if (l == VST && c == 0) hsamp = cyc + 1;
      tick();
    end
  endtask

  task automatic drive_frame(input int voff, input int short_line);
    for (int l = 0; l < LINES; l++)
      drive_line(l, (l == short_line) ? LINE - 1 : LINE, voff);
  endtask

  task automatic check_frame(input string pfx);
    check({pfx, "_active_cycles"}, act_cnt, HACT * VACT);
    check({pfx, "_rise_delay"}, rise_cyc - hsamp, HST + 2);
    check({pfx, "_first_px"}, rise_px, 0);
    check({pfx, "_first_py"}, rise_py, 0);
    check({pfx, "_last_px"}, last_px, HACT - 1);
    check({pfx, "_last_py"}, last_py, VACT - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v3;
    rst_nz = 0; ab_diff = 0; idle_nz = 0;
    clr();
    reset = 1'b1;
    set_pins(1'b0, 1'b0);
    #2 reset = 1'b0;

    // Reset held while syncs toggle
    for (int l = LINES - 5; l < LINES; l++) drive_line(l, LINE, VOFF);
    check("reset_outs_held", rst_nz, 0);
    check("reset_outs_now", outs_a, 0);
    reset = 1'b1;

    // Standard lock
    for (int f = 0; f < 3; f++) begin
      drive_frame(VOFF, -1);
      if (f == 1) check("locked_before_3rd_vedge", a_if.locked, 0);
    end
    v3 = vsamp;
    check("lock_delay", lock_rise - v3, 2);
    check("line_len", a_if.line_len, LINE);
    check("frame_lines", a_if.frame_lines, LINES);
    check("b_line_len", b_if.line_len, LINE);
    check("b_frame_lines", b_if.frame_lines, LINES);
    check("b_locked", b_if.locked, 1);
    check("no_err_lock", err_cnt, 0);
    clr();
    drive_frame(VOFF, -1);
    check_frame("std");
    check("frame_start_pulses", fs_cnt, 1);
    check("locked_std", a_if.locked, 1);

    // One short line while locked
    clr();
    drive_frame(VOFF, 10);
    check("glitch_err_pulses", err_cnt, 1);
    check("glitch_unlock", a_if.locked, 0);
    clr();
    drive_frame(VOFF, -1);
    drive_frame(VOFF, -1);
    check("glitch_not_yet", a_if.locked, 0);
    drive_frame(VOFF, -1);
    check("glitch_relock", a_if.locked, 1);
    check("glitch_relock_delay", lock_rise - vsamp, 2);
    check("glitch_no_err_after", err_cnt, 0);

    // Sync loss: both syncs idle until the h counter saturates
    clr();
    set_pins(1'b0, 1'b0);
    for (int i = 0; i < 2200; i++) tick();
    check("loss_err_pulses", err_cnt, 1);
    check("loss_err_delay", err_cyc - last_h, 2050);
    check("loss_unlock", a_if.locked, 0);
    check("loss_no_active", act_cnt, 0);

    // Coincident h/v edges
    clr();
    for (int f = 0; f < 3; f++) drive_frame(0, -1);
    check("coin_locked", a_if.locked, 1);
    check("coin_no_err", err_cnt, 0);
    check("coin_frame_lines", a_if.frame_lines, LINES - 1);
    check("coin_line_len", a_if.line_len, LINE);
    clr();
    drive_frame(0, -1);
    check_frame("coin");
    check("coin_still_locked", a_if.locked, 1);

    // Reset mid-frame
    for (int l = 0; l < 10; l++) drive_line(l, LINE, 0);
    check("pre_reset_locked", a_if.locked, 1);
    reset = 1'b0;
    #1;
    check("midreset_a_zero", outs_a, 0);
    check("midreset_b_zero", outs_b, 0);
    reset = 1'b1;
    for (int l = 10; l < LINES; l++) drive_line(l, LINE, 0);
    clr();
    drive_frame(0, -1);
    drive_frame(0, -1);
    check("midreset_not_yet", a_if.locked, 0);
    for (int l = 0; l < 6; l++) drive_line(l, LINE, 0);
    check("midreset_relock", a_if.locked, 1);
    check("midreset_relock_delay", lock_rise - vsamp, 2);

    check("polarity_equiv", ab_diff, 0);
    check("idle_coords_zero", idle_nz, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
